// File: rtl/pipe_if.sv
// rtl/pipe_if.sv - MIPS246 instruction fetch stage with IF/ID pipeline register
// Holds the PC, picks the next PC from decode-stage control, and feeds decode.
module pipe_if #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter int unsigned DELAY_SLOT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [17:0] imm18,
  input  logic [27:0] index28,
  input  logic [31:0] rd1,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] instr_d,
  output logic [31:0] pc4_d,
  output logic        valid_d
);

  logic [31:0] pc4;
  logic [31:0] target;
  logic        redirect;
  logic        unused_rd1_lsbs;

  assign imem_addr       = pc;
  assign pc4             = pc + 32'd4;
  assign unused_rd1_lsbs = ^rd1[1:0];

  // A bubble in decode carries no control transfer, so its pcsource is ignored.
  assign redirect = valid_d && (pcsource != 2'b00);

  always_comb begin
    target = pc4;
    case (pcsource)
      2'b01:   target = pc4_d + {{14{imm18[17]}}, imm18};
      2'b10:   target = {rd1[31:2], 2'b00};
      2'b11:   target = {pc4_d[31:28], index28};
      default: target = pc4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      instr_d <= NOP_INSTR;
      pc4_d   <= 32'h0000_0000;
      valid_d <= 1'b0;
    end else if (stall) begin
      pc      <= pc;
      instr_d <= instr_d;
      pc4_d   <= pc4_d;
      valid_d <= valid_d;
    end else if (redirect) begin
      // An outstanding fetch is abandoned; the new address goes out next cycle.
      pc <= target;
      if ((DELAY_SLOT != 0) && imem_ready) begin
        instr_d <= imem_rdata;
        pc4_d   <= pc4;
        valid_d <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end else if (!imem_ready) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else begin
      pc      <= pc4;
      instr_d <= imem_rdata;
      pc4_d   <= pc4;
      valid_d <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_if.sv
// tb/tb_pipe_if.sv - scoreboard bench for pipe_if, with and without delay slot
module tb_pipe_if;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } st_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  pcsource;
  logic [17:0] imm18;
  logic [27:0] index28;
  logic [31:0] rd1;
  logic        imem_ready;

  logic [31:0] a_addr, a_rdata, a_pc, a_instr, a_pc4;
  logic        a_valid;
  logic [31:0] b_addr, b_rdata, b_pc, b_instr, b_pc4;
  logic        b_valid;

  int checks   = 0;
  int failures = 0;

  st_t m0, m1;
  st_t q0[$];
  st_t q1[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign a_rdata = mem_word(a_addr);
  assign b_rdata = mem_word(b_addr);

  pipe_if #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .DELAY_SLOT(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pcsource(pcsource), .imm18(imm18),
    .index28(index28), .rd1(rd1), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .imem_ready(imem_ready), .pc(a_pc), .instr_d(a_instr), .pc4_d(a_pc4),
    .valid_d(a_valid)
  );

  pipe_if #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .DELAY_SLOT(1)) dut_ds (
    .clk(clk), .rst(rst), .stall(stall), .pcsource(pcsource), .imm18(imm18),
    .index28(index28), .rd1(rd1), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .imem_ready(imem_ready), .pc(b_pc), .instr_d(b_instr), .pc4_d(b_pc4),
    .valid_d(b_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic st_t model(input st_t s, input bit ds);
    st_t n;
    logic [31:0] tgt;
    n = s;
    if (stall) return s;
    case (pcsource)
      2'b01:   tgt = s.pc4 + {{14{imm18[17]}}, imm18};
      2'b10:   tgt = rd1 & 32'hFFFF_FFFC;
      default: tgt = {s.pc4[31:28], index28};
    endcase
    if (s.valid && pcsource != 2'b00) begin
      n.pc = tgt;
      if (ds && imem_ready) begin
        n.instr = mem_word(s.pc);
        n.pc4   = s.pc + 32'd4;
        n.valid = 1'b1;
      end else begin
        n.instr = NOP;
        n.valid = 1'b0;
      end
    end else if (!imem_ready) begin
      n.instr = NOP;
      n.valid = 1'b0;
    end else begin
      n.pc    = s.pc + 32'd4;
      n.instr = mem_word(s.pc);
      n.pc4   = s.pc + 32'd4;
      n.valid = 1'b1;
    end
    return n;
  endfunction

  task automatic reset_models();
    m0 = '{pc: 32'h0, instr: NOP, pc4: 32'h0, valid: 1'b0};
    m1 = m0;
  endtask

  // Expected state is queued when inputs are applied, compared after the edge.
  task automatic step();
    st_t e0, e1;
    m0 = model(m0, 1'b0);
    m1 = model(m1, 1'b1);
    q0.push_back(m0);
    q1.push_back(m1);
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    check("pc_ds0",    a_pc,    e0.pc);
    check("addr_ds0",  a_addr,  e0.pc);
    check("instr_ds0", a_instr, e0.instr);
    check("pc4_ds0",   a_pc4,   e0.pc4);
    check("valid_ds0", {31'b0, a_valid}, {31'b0, e0.valid});
    check("pc_ds1",    b_pc,    e1.pc);
    check("addr_ds1",  b_addr,  e1.pc);
    check("instr_ds1", b_instr, e1.instr);
    check("pc4_ds1",   b_pc4,   e1.pc4);
    check("valid_ds1", {31'b0, b_valid}, {31'b0, e1.valid});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},    a_pc,    32'h0);
    check({tag, "_instr"}, a_instr, NOP);
    check({tag, "_pc4"},   a_pc4,   32'h0);
    check({tag, "_valid"}, {31'b0, a_valid}, 32'h0);
    check({tag, "_pc_b"},  b_pc,    32'h0);
    check({tag, "_val_b"}, {31'b0, b_valid}, 32'h0);
  endtask

  task automatic drive(input logic [1:0] src, input logic rdy);
    pcsource   = src;
    imem_ready = rdy;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; pcsource = 2'b00; imm18 = '0; index28 = '0;
    rd1 = '0; imem_ready = 1'b1;
    reset_models();
    #3;
    check_reset_state("reset");
    #9 rst = 1'b1;

    // Sequential fetch from the reset PC
    drive(2'b00, 1'b1);
    step();
    check("seq0_instr", a_instr, mem_word(32'h0));
    check("seq0_pc4",   a_pc4,   32'h4);
    step();
    check("seq1_pc4",   a_pc4,   32'h8);
    step();
    check("seq2_pc4",   a_pc4,   32'hC);
    check("seq2_valid", {31'b0, a_valid}, 32'h1);

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    check_reset_state("async");
    reset_models();
    #1 rst = 1'b1;
    step();

    // Branch with pc4_d = 0x100, offset -16
    drive(2'b10, 1'b1); rd1 = 32'h0000_00FC;
    step();
    drive(2'b00, 1'b1);
    step();
    check("br_pc4_setup", a_pc4, 32'h100);
    drive(2'b01, 1'b1); imm18 = 18'h3FFF0;
    step();
    check("br_pc",        a_pc,    32'h0000_00F0);
    check("br_bubble",    {31'b0, a_valid}, 32'h0);
    check("br_slot",      b_instr, mem_word(32'h100));
    check("br_slot_v",    {31'b0, b_valid}, 32'h1);
    drive(2'b00, 1'b1);
    step();
    check("br_target",    a_instr, mem_word(32'h0000_00F0));

    // Jumps: j with pc4_d = 0x9000_0010, then jr with unaligned rs
    drive(2'b10, 1'b1); rd1 = 32'h9000_000F;
    step();
    drive(2'b00, 1'b1);
    step();
    check("j_pc4_setup", a_pc4, 32'h9000_0010);
    drive(2'b11, 1'b1); index28 = 28'h000_0400;
    step();
    check("j_pc", a_pc, 32'h9000_0400);
    drive(2'b00, 1'b1);
    step();
    drive(2'b10, 1'b1); rd1 = 32'h0000_1237;
    step();
    check("jr_pc", a_pc, 32'h0000_1234);
    drive(2'b00, 1'b1);
    step();

    // Stall holds everything; the pending branch is taken afterwards
    stall = 1'b1; drive(2'b01, 1'b1); imm18 = 18'h00040;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",  a_pc,  32'h0000_1238);
      check("stall_pc4", a_pc4, 32'h0000_1238);
    end
    stall = 1'b0;
    step();
    check("post_stall_pc", a_pc, 32'h0000_1278);

    // Memory wait at 0x20
    drive(2'b00, 1'b1);
    step();
    drive(2'b10, 1'b1); rd1 = 32'h0000_0020;
    step();
    drive(2'b00, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("wait_addr",  a_addr, 32'h0000_0020);
      check("wait_valid", {31'b0, a_valid}, 32'h0);
    end
    drive(2'b00, 1'b1);
    step();
    check("wait_instr", a_instr, mem_word(32'h0000_0020));
    check("wait_pc4",   a_pc4,   32'h0000_0024);

    // Redirect during a wait abandons the fetch from 0x24
    drive(2'b11, 1'b0); index28 = 28'h000_0300;
    step();
    check("wait_redir_pc", a_pc, 32'h0000_0300);
    drive(2'b00, 1'b1);
    step();
    check("wait_redir_instr", a_instr, mem_word(32'h0000_0300));

    // pcsource ignored while valid_d is 0
    drive(2'b00, 1'b0);
    step();
    drive(2'b01, 1'b1); imm18 = 18'h00100;
    step();
    check("gate_pc", a_pc, 32'h0000_0308);

    // PC wrap
    drive(2'b10, 1'b1); rd1 = 32'hFFFF_FFFF;
    step();
    check("wrap_setup", a_pc, 32'hFFFF_FFFC);
    drive(2'b00, 1'b1);
    step();
    check("wrap_pc",  a_pc,  32'h0000_0000);
    check("wrap_pc4", a_pc4, 32'h0000_0000);

    check("sb_empty", q0.size() + q1.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
